// File: rtl/get_reg_pkg.sv
// Register-index to ABI-mnemonic tables, packed ASCII right-justified with NUL fill.
// FPR_NAMES is only referenced when GET_REG_FP_EN is defined.
package get_reg_pkg;

  typedef logic [31:0] reg_name_t;
  typedef logic [5:0]  reg_idx_t;

  localparam reg_name_t NAME_INVALID = 32'h3F3F_3F3F;

  localparam reg_name_t GPR_NAMES [32] = '{
    32'h7A65_726F, 32'h0000_7261, 32'h0000_7370, 32'h0000_6770,  // zero ra sp gp
    32'h0000_7470, 32'h0000_7430, 32'h0000_7431, 32'h0000_7432,  // tp t0-t2
    32'h0000_7330, 32'h0000_7331, 32'h0000_6130, 32'h0000_6131,  // s0 s1 a0 a1
    32'h0000_6132, 32'h0000_6133, 32'h0000_6134, 32'h0000_6135,
    32'h0000_6136, 32'h0000_6137, 32'h0000_7332, 32'h0000_7333,  // a6 a7 s2 s3
    32'h0000_7334, 32'h0000_7335, 32'h0000_7336, 32'h0000_7337,
    32'h0000_7338, 32'h0000_7339, 32'h0073_3130, 32'h0073_3131,  // s8 s9 s10 s11
    32'h0000_7433, 32'h0000_7434, 32'h0000_7435, 32'h0000_7436   // t3-t6
  };

  localparam reg_name_t FPR_NAMES [32] = '{
    32'h0066_7430, 32'h0066_7431, 32'h0066_7432, 32'h0066_7433,  // ft0-ft3
    32'h0066_7434, 32'h0066_7435, 32'h0066_7436, 32'h0066_7437,
    32'h0066_7330, 32'h0066_7331, 32'h0066_6130, 32'h0066_6131,  // fs0 fs1 fa0 fa1
    32'h0066_6132, 32'h0066_6133, 32'h0066_6134, 32'h0066_6135,
    32'h0066_6136, 32'h0066_6137, 32'h0066_7332, 32'h0066_7333,  // fa6 fa7 fs2 fs3
    32'h0066_7334, 32'h0066_7335, 32'h0066_7336, 32'h0066_7337,
    32'h0066_7338, 32'h0066_7339, 32'h6673_3130, 32'h6673_3131,  // fs8 fs9 fs10 fs11
    32'h0066_7438, 32'h0066_7439, 32'h6674_3130, 32'h6674_3131   // ft8-ft11
  };

endpackage

// File: rtl/get_reg_lut.sv
// Combinational register-index to ABI-name lookup; FP map present only with GET_REG_FP_EN.
module get_reg_lut
  import get_reg_pkg::*;
(
  input  reg_idx_t  idx_i,
`ifdef GET_REG_FP_EN
  input  logic      fp_i,
`endif
  output reg_name_t name_o,
  output logic      err_o
);

  always_comb begin
    err_o  = idx_i[5];
    name_o = NAME_INVALID;
    if (!idx_i[5]) begin
`ifdef GET_REG_FP_EN
      name_o = fp_i ? FPR_NAMES[idx_i[4:0]] : GPR_NAMES[idx_i[4:0]];
`else
      name_o = GPR_NAMES[idx_i[4:0]];
`endif
    end
  end

endmodule

// File: rtl/get_reg.sv
// Registered RISC-V register-name lookup (1-cycle latency, valid strobe).
// Optional FP register names enabled by defining GET_REG_FP_EN.
module get_reg
  import get_reg_pkg::*;
#(
  parameter int unsigned NAME_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
`ifdef GET_REG_FP_EN
  input  logic              in_fp,
`endif
  output logic              out_valid,
  output logic [NAME_W-1:0] out_name,
  output logic              out_err
);

  reg_name_t name_d, name_q;
  logic      err_d, err_q;
  logic      valid_q;

  get_reg_lut u_lut (
    .idx_i  (in_idx),
`ifdef GET_REG_FP_EN
    .fp_i   (in_fp),
`endif
    .name_o (name_d),
    .err_o  (err_d)
  );

  // Name/err hold their last value while idle; only valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      name_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        name_q <= name_d;
        err_q  <= err_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_name  = name_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_get_reg.sv
// Self-checking bench for get_reg: directed steps plus random traffic vs a string-based name model.
module tb_get_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  in_idx;
  logic        in_fp;
  logic        out_valid;
  logic [31:0] out_name;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  logic        exp_valid;
  logic [31:0] exp_name;
  logic        exp_err;

  always #5 clk = ~clk;

  get_reg #(.NAME_W(32), .IDX_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_idx    (in_idx),
`ifdef GET_REG_FP_EN
    .in_fp     (in_fp),
`endif
    .out_valid (out_valid),
    .out_name  (out_name),
    .out_err   (out_err)
  );

  function automatic logic [31:0] pack_str(input string s);
    logic [31:0] n = '0;
    for (int i = 0; i < s.len(); i++) n = {n[23:0], s[i]};
    return n;
  endfunction

  function automatic logic [31:0] model_name(input int idx, input bit fp);
    string s;
    if (idx >= 32) return 32'h3F3F_3F3F;
    if (fp) begin
      if (idx <= 7)       s = $sformatf("ft%0d", idx);
      else if (idx <= 9)  s = $sformatf("fs%0d", idx - 8);
      else if (idx <= 17) s = $sformatf("fa%0d", idx - 10);
      else if (idx <= 27) s = $sformatf("fs%0d", idx - 16);
      else                s = $sformatf("ft%0d", idx - 20);
    end else begin
      case (idx)
        0: s = "zero";
        1: s = "ra";
        2: s = "sp";
        3: s = "gp";
        4: s = "tp";
        default: begin
          if (idx <= 7)       s = $sformatf("t%0d", idx - 5);
          else if (idx <= 9)  s = $sformatf("s%0d", idx - 8);
          else if (idx <= 17) s = $sformatf("a%0d", idx - 10);
          else if (idx <= 27) s = $sformatf("s%0d", idx - 16);
          else                s = $sformatf("t%0d", idx - 25);
        end
      endcase
    end
    return pack_str(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock step: drive at negedge, update the expectation, check just after posedge.
  task automatic step(input logic r, input logic v, input logic [5:0] idx, input logic fp);
    @(negedge clk);
    rst_n = r; in_valid = v; in_idx = idx; in_fp = fp;
    if (!r) begin
      exp_valid = 1'b0; exp_name = '0; exp_err = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
`ifdef GET_REG_FP_EN
        exp_name = model_name(int'(idx), fp);
`else
        exp_name = model_name(int'(idx), 1'b0);
`endif
        exp_err = idx[5];
      end
    end
    @(posedge clk);
    #1;
    chk($sformatf("valid idx%0d", idx), {31'd0, out_valid}, {31'd0, exp_valid});
    chk($sformatf("name idx%0d", idx), out_name, exp_name);
    chk($sformatf("err idx%0d", idx), {31'd0, out_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_fp = 1'b0;
    exp_valid = 1'b0; exp_name = '0; exp_err = 1'b0;

    // Reset dominates a pending request
    step(1'b0, 1'b1, 6'd1, 1'b0);
    step(1'b0, 1'b1, 6'd1, 1'b0);
    chk("reset name", out_name, 32'h0);

    // Back-to-back sweep with spot checks
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, 6'(i), 1'b0);
      case (i)
        0:  chk("spot idx0",  out_name, 32'h7A65_726F);
        2:  chk("spot idx2",  out_name, 32'h0000_7370);
        10: chk("spot idx10", out_name, 32'h0000_6130);
        27: chk("spot idx27", out_name, 32'h0073_3131);
        31: chk("spot idx31", out_name, 32'h0000_7436);
        default: ;
      endcase
    end

    // Out-of-range boundaries then recovery
    step(1'b1, 1'b1, 6'd32, 1'b0);
    chk("oor32 name", out_name, 32'h3F3F_3F3F);
    chk("oor32 err", {31'd0, out_err}, 32'd1);
    step(1'b1, 1'b1, 6'd63, 1'b0);
    chk("oor63 name", out_name, 32'h3F3F_3F3F);
    step(1'b1, 1'b1, 6'd8, 1'b0);
    chk("idx8 name", out_name, 32'h0000_7330);
    chk("idx8 err", {31'd0, out_err}, 32'd0);

    // Single pulse then idle: valid for one cycle, name holds
    step(1'b1, 1'b1, 6'd26, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 6'(i + 40), 1'b0);
      chk("idle hold", out_name, 32'h0073_3130);
    end

    // Reset mid-sweep then resume
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 6'(i), 1'b0);
    step(1'b0, 1'b1, 6'd6, 1'b0);
    for (int i = 6; i < 12; i++) step(1'b1, 1'b1, 6'(i), 1'b0);

`ifdef GET_REG_FP_EN
    step(1'b1, 1'b1, 6'd0, 1'b1);
    chk("fp idx0", out_name, 32'h0066_7430);
    step(1'b1, 1'b1, 6'd31, 1'b1);
    chk("fp idx31", out_name, 32'h6674_3131);
    step(1'b1, 1'b1, 6'd9, 1'b1);
    chk("fp idx9", out_name, 32'h0066_7331);
`endif

    // Random traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
